// File: rtl/vram_arbiter.sv
// Video RAM arbiter: decodes the CPU I/O register window, queues CPU writes
// in a small FIFO and drains them into RAM cycles the pixel fetcher leaves idle.
module vram_arbiter #(
  parameter int ADDR_BITS  = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write,
  input  logic                 iorq,
  input  logic [1:0]           chipsel,
  input  logic [7:0]           data,
  input  logic                 fetch_req,
  input  logic [ADDR_BITS-1:0] fetch_addr,
  output logic [7:0]           fetch_data,
  output logic                 fetch_valid,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_we,
  input  logic [7:0]           ram_rdata,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef logic [ADDR_BITS-1:0] addr_t;

  logic          strb_q, strb_d;
  addr_t         addr_q, addr_d;
  logic          autoinc_q, autoinc_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          busy_q, busy_d;

  addr_t         fifo_addr_q [FIFO_DEPTH];
  logic [7:0]    fifo_data_q [FIFO_DEPTH];

  logic strobe;
  logic det;
  logic empty;
  logic full;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  assign strobe   = iorq & write;
  assign det      = strobe & ~strb_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  // A write only gets the RAM when the fetcher leaves it idle.
  assign pop      = ~rst & ~fetch_req & ~empty;
  assign push_req = det & (chipsel == 2'd2);
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & ~push;

  always_comb begin
    strb_d        = strobe;
    addr_d        = addr_q;
    autoinc_d     = autoinc_q;
    overflow_d    = overflow_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    fetch_valid_d = fetch_req;
    if (det) begin
      unique case (chipsel)
        2'd0: addr_d[7:0] = data;
        2'd1: addr_d[ADDR_BITS-1:8] = data[ADDR_BITS-9:0];
        2'd2: if (push && autoinc_q) addr_d = addr_q + addr_t'(1);
        2'd3: begin
          autoinc_d = data[0];
          if (data[7]) overflow_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (drop) overflow_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    busy_d  = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q        <= 1'b0;
      addr_q        <= '0;
      autoinc_q     <= 1'b1;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      strb_q        <= strb_d;
      addr_q        <= addr_d;
      autoinc_q     <= autoinc_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fetch_valid_q <= fetch_valid_d;
      busy_q        <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= addr_q;
      fifo_data_q[wr_ptr_q] <= data;
    end
  end

  // The RAM's own output register supplies the fetch latency.
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_valid_q ? ram_rdata : 8'h00;
  assign ram_we      = pop;
  assign ram_addr    = fetch_req ? fetch_addr : fifo_addr_q[rd_ptr_q];
  assign ram_wdata   = fifo_data_q[rd_ptr_q];
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic,
// checked each cycle against a queue-based model and a modelled RAM.
module tb_vram_arbiter;

  localparam int AB    = 15;
  localparam int DEPTH = 4;
  localparam int MSZ   = 1 << AB;

  typedef struct {
    logic [AB-1:0] a;
    logic [7:0]    d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic          iorq;
  logic [1:0]    chipsel;
  logic [7:0]    data;
  logic          fetch_req;
  logic [AB-1:0] fetch_addr;
  logic [7:0]    fetch_data;
  logic          fetch_valid;
  logic [AB-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          busy;
  logic          overflow;
  logic          ram_init;

  int n_assert = 0;
  int n_fail   = 0;
  int we_count = 0;

  logic [7:0] ram_mem [MSZ];
  logic [7:0] smem [MSZ];

  ent_t          q[$];
  logic [AB-1:0] m_addr;
  bit            m_autoinc;
  bit            m_ovf;
  bit            m_prev;
  bit            m_fv;
  logic [7:0]    m_fd;

  vram_arbiter #(.ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .write(write), .iorq(iorq),
    .chipsel(chipsel), .data(data),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one-cycle synchronous read, old data on collision
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < MSZ; i++) ram_mem[i] <= 8'(i * 37 + 5);
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit   exp_we;
    bit   st;
    bit   det;
    int   sz;
    ent_t e;
    #3;
    exp_we = !rst && !fetch_req && (q.size() > 0);
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    if (fetch_req) begin
      chk("ram_addr_fetch", 32'(ram_addr), 32'(fetch_addr));
    end else if (exp_we) begin
      chk("ram_addr_wr", 32'(ram_addr), 32'(q[0].a));
      chk("ram_wdata", 32'(ram_wdata), 32'(q[0].d));
    end
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("fetch_data", 32'(fetch_data), m_fv ? 32'(m_fd) : 32'h0);
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (ram_we) we_count++;
    if (rst) begin
      q.delete();
      m_addr    = '0;
      m_autoinc = 1'b1;
      m_ovf     = 1'b0;
      m_prev    = 1'b0;
      m_fv      = 1'b0;
    end else begin
      st  = iorq && write;
      det = st && !m_prev;
      sz  = q.size();
      if (fetch_req) m_fd = smem[fetch_addr];
      m_fv = fetch_req;
      if (exp_we) begin
        e = q.pop_front();
        smem[e.a] = e.d;
      end
      if (det) begin
        case (chipsel)
          2'd0: m_addr = AB'(int'(m_addr) - int'(m_addr) % 256 + int'(data));
          2'd1: m_addr = AB'(int'(data) * 256 + int'(m_addr) % 256);
          2'd2: begin
            if (sz < DEPTH || exp_we) begin
              q.push_back('{a: m_addr, d: data});
              if (m_autoinc) m_addr = AB'(int'(m_addr) + 1);
            end else begin
              m_ovf = 1'b1;
            end
          end
          default: begin
            m_autoinc = data[0];
            if (data[7]) m_ovf = 1'b0;
          end
        endcase
      end
      m_prev = st;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    iorq  = 1'b0;
    write = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic strobe(input logic [1:0] cs, input logic [7:0] d);
    chipsel = cs;
    data    = d;
    iorq    = 1'b1;
    write   = 1'b1;
    cyc();
    iorq    = 1'b0;
    write   = 1'b0;
    cyc();
  endtask

  initial begin
    int wc;
    for (int i = 0; i < MSZ; i++) smem[i] = 8'(i * 37 + 5);
    m_fd       = '0;
    rst        = 1'b1;
    ram_init   = 1'b1;
    write      = 1'b0;
    iorq       = 1'b0;
    chipsel    = '0;
    data       = '0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    cyc();
    ram_init = 1'b0;
    cyc();
    rst = 1'b0;
    idle(2);

    strobe(2'd0, 8'h34);
    strobe(2'd1, 8'h12);
    wc = we_count;
    strobe(2'd2, 8'hAA);
    idle(2);
    chk("first_write_count", 32'(we_count - wc), 32'd1);
    chk("mem_1234", 32'(ram_mem[15'h1234]), 32'hAA);
    strobe(2'd2, 8'h55);
    idle(2);
    chk("mem_1235", 32'(ram_mem[15'h1235]), 32'h55);

    wc      = we_count;
    chipsel = 2'd2;
    data    = 8'h77;
    iorq    = 1'b1;
    write   = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    idle(3);
    chk("long_strobe_writes", 32'(we_count - wc), 32'd1);
    chk("mem_1236", 32'(ram_mem[15'h1236]), 32'h77);

    wc = we_count;
    for (int i = 0; i < 64; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = AB'($urandom);
      chipsel    = 2'd2;
      data       = 8'(8'hC0 + i);
      iorq       = (i % 10 == 1) && (i < 60);
      write      = iorq;
      cyc();
    end
    chk("no_we_during_fetch", 32'(we_count - wc), 32'd0);
    chk("overflow_set", 32'(overflow), 32'd1);
    fetch_req = 1'b0;
    idle(6);
    chk("drained_writes", 32'(we_count - wc), 32'd4);
    chk("busy_after_drain", 32'(busy), 32'd0);
    strobe(2'd3, 8'h81);
    chk("overflow_cleared", 32'(overflow), 32'd0);

    strobe(2'd3, 8'h00);
    strobe(2'd0, 8'h10);
    strobe(2'd1, 8'h00);
    strobe(2'd2, 8'hA1);
    strobe(2'd2, 8'hA2);
    idle(2);
    chk("noinc_mem_0010", 32'(ram_mem[15'h0010]), 32'hA2);
    strobe(2'd3, 8'h01);
    strobe(2'd0, 8'hFF);
    strobe(2'd1, 8'hFF);
    strobe(2'd2, 8'hB1);
    strobe(2'd2, 8'hB2);
    idle(2);
    chk("wrap_mem_max", 32'(ram_mem[15'h7FFF]), 32'hB1);
    chk("wrap_mem_zero", 32'(ram_mem[15'h0000]), 32'hB2);

    fetch_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) strobe(2'd2, 8'(8'hD0 + i));
    fetch_req = 1'b0;
    strobe(2'd2, 8'hDF);
    chk("full_pop_push_ovf", 32'(overflow), 32'd0);
    idle(6);

    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) strobe(2'd2, 8'(8'hE0 + i));
    chk("busy_before_rst", 32'(busy), 32'd1);
    wc        = we_count;
    fetch_req = 1'b0;
    rst       = 1'b1;
    cyc();
    rst = 1'b0;
    idle(5);
    chk("no_writes_after_rst", 32'(we_count - wc), 32'd0);
    chk("busy_after_rst", 32'(busy), 32'd0);
    strobe(2'd2, 8'hC3);
    idle(1);
    chk("addr_zero_after_rst", 32'(ram_mem[15'h0000]), 32'hC3);

    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      fetch_req  = ($urandom_range(0, 2) != 0);
      fetch_addr = AB'($urandom);
      iorq       = ($urandom_range(0, 2) == 0);
      write      = ($urandom_range(0, 3) != 0);
      chipsel    = 2'($urandom);
      data       = 8'($urandom);
      cyc();
    end
    rst       = 1'b0;
    fetch_req = 1'b0;
    idle(8);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
